psram_port_arbiter: RTL and testbench
=====================================

// Module: psram_port_arbiter
// PURPOSE
// - Shares the single QPI PSRAM driver (psram top: address/read_write/quad_start/data_in/endcommand/data_out) between two requesters.
// - Port 0 = capture writer, port 1 = readback reader; either port may issue reads or writes.
// - Waits for init (qpi_on=1), serialises 16-bit transactions, fires one-cycle quad_start, holds operands stable until endcommand.
// - Returns read data to the requester; enforces inter-transaction gap; aborts hung transactions via watchdog.
// PARAMETERS
// - GAP_CYCLES   4     idle cycles after endcommand before next quad_start (CE high time, >=1)
// - TIMEOUT      63    max cycles from quad_start to endcommand before abort (6-bit counter)
// - FIXED_PRIO   0     0: round-robin between ports; 1: port 0 always wins
// PORTS
// - mem_clk       in   1   PSRAM/system clock, all logic on posedge
// - rst_n         in   1   asynchronous active-low reset
// - req[1:0]      in   2   per-port request level; hold with operands stable until ack
// - we[1:0]       in   2   per-port 1=write, 0=read
// - addr0/addr1   in   24  per-port word address (bit 23 ignored by driver)
// - wdata0/wdata1 in   16  per-port write data
// - ack[1:0]      out  2   one-cycle completion pulse to granted port
// - rdata         out  16  read data, valid in ack cycle of a read
// - err           out  1   sticky: watchdog abort occurred; cleared only by reset
// - busy          out  1   transaction in flight or gap running
// - qpi_on        in   1   driver init complete
// - endcommand    in   1   driver completion pulse
// - data_out      in   16  driver read data
// - address       out  24  to driver
// - read_write    out  2   to driver: 0 idle, 1 write, 2 read
// - quad_start    out  1   to driver: one-cycle start pulse
// - data_in       out  16  to driver write data
// BEHAVIOUR
// - Reset: state=INIT, ack=0, rdata=0, err=0, busy=0, address=0, read_write=0, quad_start=0, data_in=0, rr pointer=port 0.
// - Clock: posedge mem_clk only; reset is async-assert, released synchronously to mem_clk.
// - FSM INIT: stay until qpi_on=1 -> IDLE. req ignored (no ack) while in INIT.
// - IDLE: if any req, arbitrate; latch winner's addr/wdata/we into address/data_in/read_write (1 or 2) -> ISSUE.
//   Round-robin: on simultaneous req, winner = port != last served; single req wins regardless.
// - ISSUE (1 cycle): quad_start=1 -> WAIT; clear watchdog.
// - WAIT: quad_start=0; address/read_write/data_in held constant.
//   On endcommand: capture data_out into rdata if read; ack[winner]=1 for exactly one cycle -> GAP.
//   Watchdog reaches TIMEOUT first: err=1, ack[winner]=1 with rdata unchanged -> GAP.
// - GAP: read_write=0; count GAP_CYCLES then -> IDLE. busy=1 in ISSUE/WAIT/GAP.
// - Requester must drop req in the cycle after ack; a still-high req in IDLE is treated as a new request.
// - Change of req/operands of a non-granted port while another is served: no effect until IDLE arbitration.
// - qpi_on falling in IDLE -> INIT; in ISSUE/WAIT: finish or time out, then GAP -> INIT.
// - endcommand seen outside WAIT: ignored.
// - Reset mid-transaction: all outputs to reset values immediately; no ack issued for the aborted request.
// STRUCTURE
// - psram_pkg: RW_IDLE=2'd0, RW_WRITE=2'd1, RW_READ=2'd2; FSM state encoding (INIT, IDLE, ISSUE, WAIT, GAP).
// - Sub-module psram_rr_arb2: 2-way combinational grant with registered last-served pointer and FIXED_PRIO.
// - Top holds FSM, operand registers, watchdog and gap counters.
// TESTING
// - Reset, qpi_on=0, req=2'b01 for 100 cycles -> no quad_start, no ack; set qpi_on=1 -> quad_start within 2 cycles.
// - Port0 write addr=24'h000010, wdata=16'hA5C3, driver model endcommand 14 cycles later:
//   -> read_write=1, data_in=16'hA5C3 stable throughout, ack=2'b01 exactly once.
// - Port1 read addr=24'h000010, model returns 16'hA5C3 -> read_write=2, rdata=16'hA5C3 in ack cycle, ack=2'b10.
// - req=2'b11 held four transactions, FIXED_PRIO=0 -> grant order 0,1,0,1, each quad_start >= GAP_CYCLES after prior endcommand.
//   Same test with FIXED_PRIO=1 -> order 0,0,0,0.
// - Model never asserts endcommand -> ack after TIMEOUT cycles, err=1 and stays 1, next request still served.
// - Assert rst_n=0 during WAIT -> quad_start/read_write/ack/busy=0 asynchronously; after release state INIT.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared encodings for the PSRAM port arbiter: driver command codes and
// arbiter FSM states.
package psram_pkg;

  localparam logic [1:0] RW_IDLE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } psram_state_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-way grant selection. Grant is combinational; the round-robin
// preference is registered and advanced only when the grant is taken.
module psram_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic prefer1;

  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) grant_idx = FIXED_PRIO ? 1'b0 : prefer1;
    else              grant_idx = ~req[0];
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)                     prefer1 <= 1'b0;
    else if (take && grant_valid)   prefer1 <= ~grant_idx;
  end

endmodule

// File: rtl/psram_port_arbiter.sv
// Shares one QPI PSRAM driver between two requesters: serialises 16-bit
// transactions, enforces a CE-high gap and aborts hung commands.
module psram_port_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 63,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  input  logic        qpi_on,
  input  logic        endcommand,
  input  logic [15:0] data_out,
  output logic [23:0] address,
  output logic [1:0]  read_write,
  output logic        quad_start,
  output logic [15:0] data_in
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  psram_state_t     state;
  logic             winner;
  logic [5:0]       wd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_valid;
  logic             grant_idx;
  logic             take;
  logic             wait_done;

  assign take      = (state == ST_IDLE) && qpi_on;
  assign wait_done = endcommand || (wd_cnt == 6'(TIMEOUT));

  psram_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .mem_clk     (mem_clk),
    .rst_n       (rst_n),
    .req         (req),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      ack        <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      address    <= '0;
      read_write <= RW_IDLE;
      quad_start <= 1'b0;
      data_in    <= '0;
      winner     <= 1'b0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      ack        <= '0;
      quad_start <= 1'b0;
      unique case (state)
        ST_INIT: if (qpi_on) state <= ST_IDLE;
        ST_IDLE: begin
          if (!qpi_on) begin
            state <= ST_INIT;
          end else if (grant_valid) begin
            winner     <= grant_idx;
            address    <= grant_idx ? addr1  : addr0;
            data_in    <= grant_idx ? wdata1 : wdata0;
            read_write <= we[grant_idx] ? RW_WRITE : RW_READ;
            quad_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A watchdog abort still acks so the requester never stalls; rdata keeps its old value.
          if (wait_done) begin
            if (endcommand && read_write == RW_READ) rdata <= data_out;
            if (!endcommand) err <= 1'b1;
            ack[winner] <= 1'b1;
            read_write  <= RW_IDLE;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else begin
            wd_cnt <= wd_cnt + 6'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= qpi_on ? ST_IDLE : ST_INIT;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b)
// share requester inputs; each has its own PSRAM driver model.
module tb_psram_port_arbiter;

  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 63;
  localparam int          LAT = 14;

  logic        mem_clk = 1'b0;
  logic        rst_n, qpi_on, hang;
  logic [1:0]  req, we;
  logic [23:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic [1:0]  ack_a, ack_b, rw_a, rw_b;
  logic [15:0] rdata_a, rdata_b, din_a, din_b;
  logic [15:0] dout_a = '0, dout_b = '0;
  logic        err_a, err_b, busy_a, busy_b, qs_a, qs_b;
  logic        end_a = 1'b0, end_b = 1'b0;
  logic [23:0] adr_a, adr_b;

  int checks = 0;
  int failures = 0;

  always #5 mem_clk = ~mem_clk;

  psram_port_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .FIXED_PRIO(1'b0)) dut_a (
    .mem_clk(mem_clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack_a), .rdata(rdata_a), .err(err_a),
    .busy(busy_a), .qpi_on(qpi_on), .endcommand(end_a), .data_out(dout_a),
    .address(adr_a), .read_write(rw_a), .quad_start(qs_a), .data_in(din_a));

  psram_port_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .FIXED_PRIO(1'b1)) dut_b (
    .mem_clk(mem_clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack_b), .rdata(rdata_b), .err(err_b),
    .busy(busy_b), .qpi_on(qpi_on), .endcommand(end_b), .data_out(dout_b),
    .address(adr_b), .read_write(rw_b), .quad_start(qs_b), .data_in(din_b));

  // Driver models: endcommand LAT cycles after quad_start unless hang is set.
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  int          cnt_a = 0, cnt_b = 0, viol_a = 0;
  logic        act_a = 1'b0, act_b = 1'b0;
  logic [1:0]  lrw_a, lrw_b;
  logic [23:0] ladr_a, ladr_b;
  logic [15:0] ldin_a, ldin_b;

  always @(posedge mem_clk) begin
    end_a <= 1'b0;
    if (qs_a) begin
      act_a <= 1'b1; cnt_a <= LAT; lrw_a <= rw_a; ladr_a <= adr_a; ldin_a <= din_a;
    end else if (act_a) begin
      if (rst_n && (rw_a !== lrw_a || adr_a !== ladr_a || din_a !== ldin_a)) viol_a <= viol_a + 1;
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) begin
        act_a <= 1'b0;
        if (!hang) begin
          end_a <= 1'b1;
          if (lrw_a == 2'd2) dout_a <= mem_a[ladr_a[3:0]];
          else               mem_a[ladr_a[3:0]] <= ldin_a;
        end
      end
    end
  end

  always @(posedge mem_clk) begin
    end_b <= 1'b0;
    if (qs_b) begin
      act_b <= 1'b1; cnt_b <= LAT; lrw_b <= rw_b; ladr_b <= adr_b; ldin_b <= din_b;
    end else if (act_b) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) begin
        act_b <= 1'b0;
        if (!hang) begin
          end_b <= 1'b1;
          if (lrw_b == 2'd2) dout_b <= mem_b[ladr_b[3:0]];
          else               mem_b[ladr_b[3:0]] <= ldin_b;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_qs(input int limit, output int n);
    n = 0;
    while (qs_a !== 1'b1 && n < limit) begin @(negedge mem_clk); n++; end
  endtask

  task automatic wait_ack(input int limit, output int n);
    n = 0;
    while (ack_a === 2'b00 && n < limit) begin @(negedge mem_clk); n++; end
  endtask

  initial begin
    int n, qs_cnt, ack_cnt, cyc, last_end, min_gap, acks_a, acks_b;
    logic [3:0] ord_a, ord_b;

    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    rst_n = 1'b0; qpi_on = 1'b0; hang = 1'b0; req = '0; we = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge mem_clk);

    check("rst_ack", 32'(ack_a), 0);
    check("rst_rdata", 32'(rdata_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_address", 32'(adr_a), 0);
    check("rst_read_write", 32'(rw_a), 0);
    check("rst_quad_start", 32'(qs_a), 0);
    check("rst_data_in", 32'(din_a), 0);

    // Requests while the driver is still initialising must be held off.
    rst_n = 1'b1;
    req = 2'b01; we = 2'b01; addr0 = 24'h000010; wdata0 = 16'hA5C3;
    qs_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mem_clk);
      if (qs_a) qs_cnt++;
      if (ack_a != 2'b00) ack_cnt++;
    end
    check("init_no_quad_start", 32'(qs_cnt), 0);
    check("init_no_ack", 32'(ack_cnt), 0);

    qpi_on = 1'b1;
    wait_qs(2, n);
    check("init_release_quad_start", 32'(qs_a), 1);
    check("wr_read_write", 32'(rw_a), 1);
    check("wr_data_in", 32'(din_a), 32'h0000A5C3);
    check("wr_address", 32'(adr_a), 32'h00000010);
    wait_ack(40, n);
    check("wr_ack_latency", 32'(n), 32'(LAT + 2));
    check("wr_ack", 32'(ack_a), 32'b01);
    req = 2'b00;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge mem_clk);
      if (ack_a != 2'b00) ack_cnt++;
    end
    check("wr_ack_once", 32'(ack_cnt), 0);
    check("wr_operands_stable", 32'(viol_a), 0);

    // Port 1 reads back what port 0 wrote.
    req = 2'b10; we = 2'b00; addr1 = 24'h000010;
    wait_qs(20, n);
    check("rd_quad_start", 32'(qs_a), 1);
    check("rd_read_write", 32'(rw_a), 2);
    wait_ack(40, n);
    check("rd_ack", 32'(ack_a), 32'b10);
    check("rd_rdata", 32'(rdata_a), 32'h0000A5C3);
    check("rd_rdata_fixed_prio", 32'(rdata_b), 32'h0000A5C3);
    req = 2'b00;

    // Both ports held: round-robin alternates, fixed priority keeps port 0.
    we = 2'b11; addr0 = 24'h000021; wdata0 = 16'h1111; addr1 = 24'h000032; wdata1 = 16'h2222;
    req = 2'b11;
    cyc = 0; last_end = -1; min_gap = 1000; acks_a = 0; acks_b = 0; ord_a = '0; ord_b = '0;
    while (acks_a < 4 && cyc < 300) begin
      @(negedge mem_clk);
      cyc++;
      if (qs_a && last_end >= 0 && (cyc - last_end) < min_gap) min_gap = cyc - last_end;
      if (end_a) last_end = cyc;
      if (ack_a != 2'b00) begin ord_a = {ord_a[2:0], ack_a[1]}; acks_a++; end
      if (ack_b != 2'b00) begin ord_b = {ord_b[2:0], ack_b[1]}; acks_b++; end
    end
    req = 2'b00;
    check("rr_ack_count", 32'(acks_a), 4);
    check("rr_order", 32'(ord_a), 32'b0101);
    check("fixed_ack_count", 32'(acks_b), 4);
    check("fixed_order", 32'(ord_b), 32'b0000);
    check("gap_after_endcommand", 32'(min_gap >= int'(GAP)), 1);

    // Hung driver: watchdog aborts, ack still issued, rdata untouched.
    hang = 1'b1;
    we = 2'b00; addr0 = 24'h000021; req = 2'b01;
    wait_qs(20, n);
    check("tmo_quad_start", 32'(qs_a), 1);
    wait_ack(100, n);
    check("tmo_ack_latency", 32'(n), 32'(TMO + 2));
    check("tmo_ack", 32'(ack_a), 32'b01);
    check("tmo_err", 32'(err_a), 1);
    check("tmo_rdata_kept", 32'(rdata_a), 32'h0000A5C3);
    req = 2'b00; hang = 1'b0;
    repeat (10) @(negedge mem_clk);
    check("tmo_err_sticky", 32'(err_a), 1);
    check("tmo_err_fixed_prio", 32'(err_b), 1);

    req = 2'b10; addr1 = 24'h000010;
    wait_qs(20, n);
    wait_ack(40, n);
    check("post_tmo_ack", 32'(ack_a), 32'b10);
    check("post_tmo_rdata", 32'(rdata_a), 32'h0000A5C3);
    check("post_tmo_err", 32'(err_a), 1);
    req = 2'b00;

    // Reset lands mid-WAIT: outputs clear without waiting for a clock edge.
    hang = 1'b1;
    we = 2'b01; addr0 = 24'h000005; wdata0 = 16'hBEEF; req = 2'b01;
    wait_qs(20, n);
    repeat (3) @(negedge mem_clk);
    check("mid_wait_busy", 32'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_quad_start", 32'(qs_a), 0);
    check("async_read_write", 32'(rw_a), 0);
    check("async_ack", 32'(ack_a), 0);
    check("async_busy", 32'(busy_a), 0);
    check("async_busy_fixed_prio", 32'(busy_b), 0);
    check("async_err", 32'(err_a), 0);
    qpi_on = 1'b0;
    repeat (3) @(negedge mem_clk);
    rst_n = 1'b1;
    qs_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge mem_clk);
      if (qs_a) qs_cnt++;
      if (ack_a != 2'b00) ack_cnt++;
    end
    check("post_reset_init_hold", 32'(qs_cnt), 0);
    check("post_reset_no_ack", 32'(ack_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
